// File: rtl/mem_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_if
//
// Bundles every signal between the memory bus arbiter and its neighbours:
// the I-cache refill port, the D-cache miss/write port and the external
// memory bus.
//
// Handshake rules, all sampled on the rising clock edge:
//   - Cache side: ic_req / dc_req are levels. The requester holds the request
//     and its qualifiers (addr, we, wdata) stable until it sees the matching
//     one-cycle ack. ic_rdata / dc_rdata are valid only in the ack cycle
//     (dc_rdata only for reads).
//   - Memory side: mem_req is held, with mem_addr / mem_we / mem_wdata
//     stable, until mem_ack is sampled high. mem_ack is a single-cycle
//     completion, and mem_rdata is valid with it.
//
// Modports:
//   slave  - the arbiter's view (cache requests and memory responses in,
//            cache responses and the bus request out).
//   master - the environment's view: caches plus memory, the mirror image.
// -----------------------------------------------------------------------------
interface mem_bus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // I-cache refill port
    logic          ic_req;
    logic [AW-1:0] ic_addr;
    logic          ic_ack;
    logic [DW-1:0] ic_rdata;

    // D-cache miss / write port
    logic          dc_req;
    logic          dc_we;
    logic [AW-1:0] dc_addr;
    logic [DW-1:0] dc_wdata;
    logic          dc_ack;
    logic [DW-1:0] dc_rdata;
    logic          wbuf_busy;

    // External memory bus
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          bus_err;

    modport slave (
        input  ic_req, ic_addr,
        input  dc_req, dc_we, dc_addr, dc_wdata,
        input  mem_rdata, mem_ack,
        output ic_ack, ic_rdata,
        output dc_ack, dc_rdata, wbuf_busy,
        output mem_req, mem_we, mem_addr, mem_wdata, bus_err
    );

    modport master (
        output ic_req, ic_addr,
        output dc_req, dc_we, dc_addr, dc_wdata,
        output mem_rdata, mem_ack,
        input  ic_ack, ic_rdata,
        input  dc_ack, dc_rdata, wbuf_busy,
        input  mem_req, mem_we, mem_addr, mem_wdata, bus_err
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares the single external memory bus between the I-cache refill port and
// the D-cache miss/write port. D-side stores go into a one-entry posted write
// buffer: they are acknowledged at once and drained to the bus later. A bus
// watchdog aborts transactions that never see mem_ack.
//
// Parameters:
//   AW      - address width
//   DW      - data width
//   TIMEOUT - bus cycles without mem_ack before an abort; 0 disables it
//
// Ports:
//   clk  - clock
//   rst  - asynchronous, active-low reset
//   bus  - mem_bus_arbiter_if.slave with the cache ports and the memory bus:
//          ic_req/ic_addr    -> ic_ack/ic_rdata      (I-side reads)
//          dc_req/dc_we/dc_addr/dc_wdata -> dc_ack/dc_rdata (D-side)
//          wbuf_busy         posted write buffer occupied
//          mem_req/mem_we/mem_addr/mem_wdata, mem_rdata/mem_ack (bus)
//          bus_err           one-cycle pulse on a watchdog abort
//
// Every output is a flop. The FSM state is kept in the `state` signal so it
// can be observed hierarchically.
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    mem_bus_arbiter_if.slave bus
);

    // Watchdog counter width. One bit is kept when the watchdog is disabled,
    // so the vector stays legal.
    localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    // The abort fires at the end of the TIMEOUT-th bus cycle without an ack.
    // The counter starts at 0 in the first bus cycle, so that cycle is the
    // one in which the counter holds TIMEOUT-1.
    localparam logic [WDW-1:0] WD_LAST = (TIMEOUT > 0) ? WDW'(TIMEOUT - 1) : WDW'(0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUS_IRD = 2'd1,
        BUS_DRD = 2'd2,
        BUS_DWR = 2'd3
    } state_t;

    state_t         state;
    logic           last_grant;   // side that won the last I/D conflict: 0 = I, 1 = D
    logic [WDW-1:0] wd_cnt;
    logic [AW-1:0]  wbuf_addr;
    logic [DW-1:0]  wbuf_data;

    // -------------------------------------------------------------------------
    // Request qualification
    // -------------------------------------------------------------------------
    logic i_elig;
    logic drd_elig;
    logic drain_elig;
    logic d_elig;
    logic conflict;
    logic grant_d;
    logic wr_accept;
    logic wd_expire;

    // The ack terms stop a request that is still held high during its own
    // ack cycle from being served a second time.
    assign i_elig     = bus.ic_req & ~bus.ic_ack;

    // A D-read waits while the buffer holds a store. The store then reaches
    // the bus first, so a read never passes an older write.
    assign drd_elig   = bus.dc_req & ~bus.dc_we & ~bus.dc_ack & ~bus.wbuf_busy;
    assign drain_elig = bus.wbuf_busy;
    assign d_elig     = drd_elig | drain_elig;

    // On a conflict, the side that lost the previous conflict wins. After
    // reset last_grant points at I, so D wins the first conflict. Grants made
    // without a conflict leave last_grant alone.
    assign conflict   = i_elig & d_elig;
    assign grant_d    = d_elig & (~i_elig | ~last_grant);

    // The buffer takes a store in any state, as long as it is empty. The
    // !dc_ack term keeps a store held into its ack cycle from being taken
    // twice.
    assign wr_accept  = bus.dc_req & bus.dc_we & ~bus.wbuf_busy & ~bus.dc_ack;

    assign wd_expire  = (TIMEOUT > 0) && (wd_cnt == WD_LAST);

    // -------------------------------------------------------------------------
    // FSM, posted write buffer and all registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            last_grant    <= 1'b0;
            wd_cnt        <= '0;
            wbuf_addr     <= '0;
            wbuf_data     <= '0;
            bus.wbuf_busy <= 1'b0;
            bus.ic_ack    <= 1'b0;
            bus.ic_rdata  <= '0;
            bus.dc_ack    <= 1'b0;
            bus.dc_rdata  <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.bus_err   <= 1'b0;
        end else begin
            // Acks and the error flag are single-cycle pulses.
            bus.ic_ack  <= 1'b0;
            bus.dc_ack  <= 1'b0;
            bus.bus_err <= 1'b0;

            // Posted write acceptance runs independently of the bus FSM.
            // It cannot coincide with a drain completion because it needs an
            // empty buffer. It cannot coincide with a D-read ack either,
            // because the D port carries only one request at a time.
            if (wr_accept) begin
                wbuf_addr     <= bus.dc_addr;
                wbuf_data     <= bus.dc_wdata;
                bus.wbuf_busy <= 1'b1;
                bus.dc_ack    <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (i_elig | d_elig) begin
                        bus.mem_req <= 1'b1;
                        wd_cnt      <= '0;
                        if (conflict) begin
                            last_grant <= grant_d;
                        end
                        if (grant_d) begin
                            if (drain_elig) begin
                                // Draining the buffer takes priority over a D-read.
                                state         <= BUS_DWR;
                                bus.mem_we    <= 1'b1;
                                bus.mem_addr  <= wbuf_addr;
                                bus.mem_wdata <= wbuf_data;
                            end else begin
                                state         <= BUS_DRD;
                                bus.mem_we    <= 1'b0;
                                bus.mem_addr  <= bus.dc_addr;
                                bus.mem_wdata <= '0;
                            end
                        end else begin
                            state         <= BUS_IRD;
                            bus.mem_we    <= 1'b0;
                            bus.mem_addr  <= bus.ic_addr;
                            bus.mem_wdata <= '0;
                        end
                    end
                end

                default: begin
                    // BUS_IRD, BUS_DRD and BUS_DWR share completion and abort
                    // handling. They differ only in which port gets the result.
                    // If mem_ack arrives in the threshold cycle, the ack wins.
                    if (bus.mem_ack) begin
                        bus.mem_req <= 1'b0;
                        state       <= IDLE;
                        case (state)
                            BUS_IRD: begin
                                bus.ic_rdata <= bus.mem_rdata;
                                bus.ic_ack   <= 1'b1;
                            end
                            BUS_DRD: begin
                                bus.dc_rdata <= bus.mem_rdata;
                                bus.dc_ack   <= 1'b1;
                            end
                            default: begin
                                // The drain finished. The store was already
                                // acked when it was accepted.
                                bus.wbuf_busy <= 1'b0;
                            end
                        endcase
                    end else if (wd_expire) begin
                        // The watchdog gives up. Reads are completed with zero
                        // data so the requester does not stall forever, and a
                        // stuck drain discards the buffered store.
                        bus.mem_req <= 1'b0;
                        bus.bus_err <= 1'b1;
                        state       <= IDLE;
                        case (state)
                            BUS_IRD: begin
                                bus.ic_rdata <= '0;
                                bus.ic_ack   <= 1'b1;
                            end
                            BUS_DRD: begin
                                bus.dc_rdata <= '0;
                                bus.dc_ack   <= 1'b1;
                            end
                            default: begin
                                bus.wbuf_busy <= 1'b0;
                            end
                        endcase
                    end else if (TIMEOUT > 0) begin
                        // The counter stops at WD_LAST because the abort fires
                        // there, so it never wraps.
                        wd_cnt <= wd_cnt + WDW'(1);
                    end
                end
            endcase
        end
    end

endmodule
